// File: rtl/platform_pkg.sv
// Shared types and constants for the platform scroller: grid geometry, LFSR taps, FSM states.
// PLATFORM_X_JITTER_EN (optional) enables LFSR-driven x jitter on recycled rows.
package platform_pkg;

  typedef logic signed [10:0] coord_t;

  localparam int N_ROWS    = 31;
  localparam int N_COLS    = 3;
  localparam int N_PLAT    = N_ROWS * N_COLS;
  localparam int ROW_PITCH = 30;
  localparam int Y_TOP     = -162;
  localparam int X_BASE    = 342;
  localparam int X_PITCH   = 114;
  localparam int SCREEN_H  = 768;
  // Distance a recycled row jumps back up: one full table height.
  localparam int WRAP_DIST = N_ROWS * ROW_PITCH;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    StIdle,
    StScroll,
    StScan
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic coord_t reset_y(input int row);
    return coord_t'(Y_TOP + row * ROW_PITCH);
  endfunction

  function automatic coord_t reset_x(input int col);
    return coord_t'(X_BASE + col * X_PITCH);
  endfunction

endpackage

// File: rtl/platform_scroller_if.sv
// Bus between game logic (master) and the platform scroller (slave).
interface platform_scroller_if;
  import platform_pkg::*;

  logic                                    frame_tick;
  logic [5:0]                              scroll_req;
  logic signed [N_PLAT-1:0][1:0][10:0]     platforms;
  logic [N_PLAT-1:0]                       platform_activation;
  logic                                    busy;
  logic                                    overrun;
  logic [15:0]                             rows_recycled;

  modport master (
    output frame_tick, scroll_req,
    input  platforms, platform_activation, busy, overrun, rows_recycled
  );

  modport slave (
    input  frame_tick, scroll_req,
    output platforms, platform_activation, busy, overrun, rows_recycled
  );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR; advances one step per cycle while step is high.
module lfsr16
  import platform_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] state_q, state_d;

  // Next state: hold unless stepping.
  always_comb begin
    state_d = state_q;
    if (step) state_d = lfsr_next(state_q);
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= seed;
    else     state_q <= state_d;
  end

  assign q = state_q;

endmodule

// File: rtl/platform_scroller.sv
// Platform table owner: on each frame tick scrolls all platforms down, then scans rows one per
// cycle and recycles any off-screen row to the top with LFSR-driven activation.
// Optional: define PLATFORM_X_JITTER_EN to also jitter x of recycled rows from LFSR[8:3].
module platform_scroller
  import platform_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  platform_scroller_if.slave   bus
);

  state_e            state_q, state_d;
  logic [4:0]        row_q, row_d;
  logic [5:0]        scroll_q, scroll_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       recycled_q, recycled_d;
  coord_t            y_q [N_PLAT];
  coord_t            y_d [N_PLAT];
  coord_t            x_q [N_PLAT];
  coord_t            x_d [N_PLAT];
  logic [N_PLAT-1:0] act_q, act_d;

  logic              lfsr_step;
  logic [15:0]       lfsr_q;
  logic [6:0]        base;
  coord_t            row_y;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (lfsr_step),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

`ifdef PLATFORM_X_JITTER_EN
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q[15:9];
`else
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q[15:3];
`endif

  // First platform index of the row being scanned, and that row's shared y.
  assign base  = 7'({2'b00, row_q} * 7'd3);
  assign row_y = y_q[base];

  // FSM next-state and table update.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    scroll_d   = scroll_q;
    overrun_d  = overrun_q;
    recycled_d = recycled_q;
    y_d        = y_q;
    x_d        = x_q;
    act_d      = act_q;
    lfsr_step  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.frame_tick) begin
          scroll_d = bus.scroll_req;
          state_d  = StScroll;
        end
      end
      StScroll: begin
        for (int i = 0; i < N_PLAT; i++) begin
          y_d[i] = y_q[i] + coord_t'({5'b00000, scroll_q});
        end
        row_d   = '0;
        state_d = StScan;
      end
      StScan: begin
        if (row_y >= coord_t'(SCREEN_H)) begin
          for (int c = 0; c < N_COLS; c++) begin
            y_d[base + 7'(c)]   = coord_t'(row_y - coord_t'(WRAP_DIST));
            act_d[base + 7'(c)] = lfsr_q[c];
`ifdef PLATFORM_X_JITTER_EN
            x_d[base + 7'(c)]   = coord_t'(X_BASE + c * X_PITCH + int'(lfsr_q[8:3]) - 32);
`endif
          end
          // Never leave a recycled row empty.
          if (lfsr_q[2:0] == 3'b000) act_d[base + 7'd1] = 1'b1;
          lfsr_step  = 1'b1;
          recycled_d = recycled_q + 16'd1;
        end
        if (row_q == 5'(N_ROWS - 1)) state_d = StIdle;
        else                         row_d   = row_q + 5'd1;
      end
      default: state_d = StIdle;
    endcase

    // A tick that arrives mid-update is dropped but remembered.
    if (bus.frame_tick && state_q != StIdle) overrun_d = 1'b1;
  end

  assign busy_d = (state_d != StIdle);

  // State and table registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      scroll_q   <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      recycled_q <= '0;
      act_q      <= '1;
      for (int i = 0; i < N_PLAT; i++) begin
        y_q[i] <= reset_y(i / N_COLS);
        x_q[i] <= reset_x(i % N_COLS);
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      scroll_q   <= scroll_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      recycled_q <= recycled_d;
      act_q      <= act_d;
      y_q        <= y_d;
      x_q        <= x_d;
    end
  end

  // Output drive straight from registers.
  always_comb begin
    for (int i = 0; i < N_PLAT; i++) begin
      bus.platforms[i][0] = y_q[i];
      bus.platforms[i][1] = x_q[i];
    end
    bus.platform_activation = act_q;
    bus.busy                = busy_q;
    bus.overrun             = overrun_q;
    bus.rows_recycled       = recycled_q;
  end

endmodule

// File: tb/tb_platform_scroller.sv
// Directed bench for platform_scroller (default build, x jitter disabled).
module tb_platform_scroller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycles;

  platform_scroller_if bus ();

  platform_scroller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] py(input int i);
    return 32'($signed(bus.platforms[i][0]));
  endfunction

  function automatic logic signed [31:0] px(input int i);
    return 32'($signed(bus.platforms[i][1]));
  endfunction

  function automatic logic signed [31:0] act3(input int row);
    logic [92:0] a;
    a = bus.platform_activation;
    return {29'b0, a[row*3+2], a[row*3+1], a[row*3]};
  endfunction

  // Pulse frame_tick for one cycle.
  task automatic tick(input logic [5:0] s);
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b1;
    bus.scroll_req = s;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
  endtask

  // Wait (bounded) for busy to drop; cycles counts edges from the tick edge onward.
  task automatic wait_idle(output int n);
    n = 1;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.scroll_req = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_y0",   py(0), -162);
    check("rst_x0",   px(0), 342);
    check("rst_y92",  py(92), 738);
    check("rst_x92",  px(92), 570);
    check("rst_act",  {31'b0, &bus.platform_activation}, 1);
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_ovr",  {31'b0, bus.overrun}, 0);
    check("rst_rec",  {16'b0, bus.rows_recycled}, 0);

    // Frame 1: scroll 10, nothing recycles
    tick(6'd10);
    check("f1_busy_hi", {31'b0, bus.busy}, 1);
    wait_idle(cycles);
    check("f1_latency", cycles, 33);
    check("f1_y92", py(92), 748);
    check("f1_y0",  py(0), -152);
    check("f1_rec", {16'b0, bus.rows_recycled}, 0);

    // Frame 2: scroll 30, row 30 reaches 778 and recycles; seed [2:0]=001
    tick(6'd30);
    wait_idle(cycles);
    check("f2_y90",  py(90), -152);
    check("f2_y91",  py(91), -152);
    check("f2_y92",  py(92), -152);
    check("f2_act30", act3(30), 1);
    check("f2_rec",  {16'b0, bus.rows_recycled}, 1);
    check("f2_x92",  px(92), 570);
    check("f2_y87",  py(87), 748);
    check("f2_act29", act3(29), 7);

    // Frame 3: row 29 recycles with LFSR 0xE270 ([2:0]=0) -> column 1 forced
    tick(6'd30);
    wait_idle(cycles);
    check("f3_y87",   py(87), -152);
    check("f3_act29", act3(29), 2);
    check("f3_y90",   py(90), -122);
    check("f3_rec",   {16'b0, bus.rows_recycled}, 2);
    check("f3_ovr",   {31'b0, bus.overrun}, 0);

    // Frame 4: scroll 20; second tick 5 cycles into busy is ignored
    tick(6'd20);
    repeat (4) @(posedge clk);
    #1;
    bus.frame_tick = 1'b1;
    bus.scroll_req = 6'd63;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    wait_idle(cycles);
    check("f4_ovr",   {31'b0, bus.overrun}, 1);
    check("f4_y0",    py(0), -72);
    check("f4_y84",   py(84), -162);
    check("f4_act28", act3(28), 2);
    check("f4_y87",   py(87), -132);
    check("f4_y81",   py(81), 738);
    check("f4_rec",   {16'b0, bus.rows_recycled}, 3);
    repeat (3) @(posedge clk);
    #1;
    check("f4_idle_busy", {31'b0, bus.busy}, 0);

    // Reset 10 cycles into SCAN
    tick(6'd5);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, bus.busy}, 0);
    check("mid_rst_ovr",  {31'b0, bus.overrun}, 0);
    check("mid_rst_rec",  {16'b0, bus.rows_recycled}, 0);
    check("mid_rst_y0",   py(0), -162);
    check("mid_rst_y84",  py(84), 678);
    check("mid_rst_y92",  py(92), 738);
    check("mid_rst_act",  {31'b0, &bus.platform_activation}, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset the LFSR is reseeded: same recycle as frame 2
    tick(6'd10);
    wait_idle(cycles);
    check("post_latency", cycles, 33);
    tick(6'd30);
    wait_idle(cycles);
    check("post_act30", act3(30), 1);
    check("post_y92",   py(92), -152);
    check("post_rec",   {16'b0, bus.rows_recycled}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
